timer_delay_scheduler: RTL and testbench



---
 rtl/timer_sched_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/timer_delay_scheduler.sv | 116 +++++++++++
 tb/tb_timer_delay_scheduler.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared types and constants for the timer delay scheduler: FSM states,
// timer register map and the registered bus-write bundle.
package timer_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_WAIT, S_STOP, S_CLR, S_DONE
  } state_t;

  localparam logic [2:0] TMR_ADDR_STATUS = 3'd0;
  localparam logic [2:0] TMR_ADDR_CTRL   = 3'd1;
  localparam logic [2:0] TMR_ADDR_PERL   = 3'd2;
  localparam logic [2:0] TMR_ADDR_PERH   = 3'd3;

  localparam logic [15:0] CTRL_START_ONESHOT = 16'h0005;
  localparam logic [15:0] CTRL_STOP          = 16'h0008;

  typedef struct packed {
    logic        cs;
    logic        wr_n;
    logic [2:0]  addr;
    logic [15:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs: 1'b0, wr_n: 1'b1, addr: 3'd0, data: 16'h0000};

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: the first asserted request at or after
// ptr (wrapping) wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  int k;

  // Scan from the farthest offset down so the nearest hit is assigned last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    k           = 0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      k = (int'(ptr) + j) % NUM_REQ;
      if (req[k[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = k[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/timer_delay_scheduler.sv
// Shares one Avalon interval timer among NUM_REQ requesters: round-robin
// grant, program period, one-shot start, wait irq (or cancel), clear, done.
module timer_delay_scheduler
  import timer_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*32-1:0] req_delay,
  output logic [NUM_REQ-1:0]    done,
  output logic                  busy,
  output logic [IDX_W-1:0]      owner,
  output logic [2:0]            tmr_address,
  output logic                  tmr_chipselect,
  output logic                  tmr_write_n,
  output logic [15:0]           tmr_writedata,
  input  logic                  tmr_irq
);

  state_t               state, nxt_state;
  logic [IDX_W-1:0]     ptr, nxt_ptr, nxt_owner;
  logic [31:0]          delay, nxt_delay;
  logic                 cancel, nxt_cancel, nxt_busy;
  logic [NUM_REQ-1:0]   nxt_done;
  bus_t                 bus, nxt_bus;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req         (req),
    .ptr         (ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    nxt_state  = state;
    nxt_ptr    = ptr;
    nxt_owner  = owner;
    nxt_delay  = delay;
    nxt_cancel = cancel;
    case (state)
      S_IDLE: if (grant_valid) begin
        nxt_state  = S_WR_PL;
        nxt_owner  = grant_idx;
        nxt_cancel = 1'b0;
        nxt_delay  = req_delay[int'(grant_idx)*32 +: 32];
        // A load of 0 never produces a zero crossing, so it would never fire.
        if (nxt_delay == 32'd0) nxt_delay = 32'd1;
        if (int'(grant_idx) == NUM_REQ - 1) nxt_ptr = '0;
        else                                nxt_ptr = grant_idx + 1'b1;
      end
      S_WR_PL:   nxt_state = S_WR_PH;
      S_WR_PH:   nxt_state = S_WR_CTRL;
      S_WR_CTRL: nxt_state = S_WAIT;
      S_WAIT: begin
        if (tmr_irq)         nxt_state = S_CLR;
        else if (!req[owner]) nxt_state = S_STOP;
      end
      S_STOP: begin
        nxt_state  = S_CLR;
        nxt_cancel = 1'b1;
      end
      S_CLR:   nxt_state = S_DONE;
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the flops present them
    // during the cycle the FSM is in that state.
    nxt_bus = BUS_IDLE;
    case (nxt_state)
      S_WR_PL:   nxt_bus = '{cs: 1'b1, wr_n: 1'b0, addr: TMR_ADDR_PERL,   data: nxt_delay[15:0]};
      S_WR_PH:   nxt_bus = '{cs: 1'b1, wr_n: 1'b0, addr: TMR_ADDR_PERH,   data: nxt_delay[31:16]};
      S_WR_CTRL: nxt_bus = '{cs: 1'b1, wr_n: 1'b0, addr: TMR_ADDR_CTRL,   data: CTRL_START_ONESHOT};
      S_STOP:    nxt_bus = '{cs: 1'b1, wr_n: 1'b0, addr: TMR_ADDR_CTRL,   data: CTRL_STOP};
      S_CLR:     nxt_bus = '{cs: 1'b1, wr_n: 1'b0, addr: TMR_ADDR_STATUS, data: 16'h0000};
      default:   nxt_bus = BUS_IDLE;
    endcase

    nxt_done = '0;
    if (nxt_state == S_DONE && !nxt_cancel) nxt_done[nxt_owner] = 1'b1;
    nxt_busy = (nxt_state != S_IDLE) && (nxt_state != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ptr    <= '0;
      owner  <= '0;
      delay  <= '0;
      cancel <= 1'b0;
      done   <= '0;
      busy   <= 1'b0;
      bus    <= BUS_IDLE;
    end else begin
      state  <= nxt_state;
      ptr    <= nxt_ptr;
      owner  <= nxt_owner;
      delay  <= nxt_delay;
      cancel <= nxt_cancel;
      done   <= nxt_done;
      busy   <= nxt_busy;
      bus    <= nxt_bus;
    end
  end

  assign tmr_chipselect = bus.cs;
  assign tmr_write_n    = bus.wr_n;
  assign tmr_address    = bus.addr;
  assign tmr_writedata  = bus.data;

endmodule

// File: tb/tb_timer_delay_scheduler.sv
// Bench for timer_delay_scheduler with a behavioural interval-timer slave and
// a round-robin reference model of grant order and timer writes.
module tb_timer_delay_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_delay;
  logic [3:0]   done;
  logic         busy;
  logic [1:0]   owner;
  logic [2:0]   tmr_address;
  logic         tmr_chipselect;
  logic         tmr_write_n;
  logic [15:0]  tmr_writedata;
  logic         tmr_irq;

  timer_delay_scheduler #(.NUM_REQ(4), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .req(req), .req_delay(req_delay),
    .done(done), .busy(busy), .owner(owner),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_irq(tmr_irq)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [2:0] a; logic [15:0] d; } wr_t;
  typedef struct { int cyc; int idx; } dn_t;

  wr_t wq[$];  // observed writes
  wr_t ew[$];  // expected writes
  dn_t dq[$];  // observed done pulses
  int  ed[$];  // expected done order
  int  iq[$];  // irq rise cycles
  int  n_checks = 0, n_fail = 0;
  int  cyc = 0;
  int  mptr = 0;
  int  hold_n[4];

  // Interval timer slave model
  logic [31:0] t_per = '0, t_cnt = '0;
  logic        t_run = 1'b0, t_to = 1'b0, t_ito = 1'b0;
  assign tmr_irq = t_to & t_ito;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge tmr_irq) iq.push_back(cyc);

  always @(negedge clk) begin
    wr_t w;
    dn_t dn;
    if (tmr_chipselect && !tmr_write_n) begin
      w.cyc = cyc; w.a = tmr_address; w.d = tmr_writedata;
      wq.push_back(w);
      case (tmr_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito <= tmr_writedata[0];
          if (tmr_writedata[3]) t_run <= 1'b0;
          if (tmr_writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
        end
        3'd2: begin t_per[15:0]  <= tmr_writedata; t_run <= 1'b0; end
        3'd3: begin t_per[31:16] <= tmr_writedata; t_run <= 1'b0; end
        default: ;
      endcase
    end else if (t_run) begin
      if (t_cnt == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
      else t_cnt <= t_cnt - 1;
    end
    for (int i = 0; i < 4; i++)
      if (done[i]) begin dn.cyc = cyc; dn.idx = i; dq.push_back(dn); end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_logs();
    wq.delete(); ew.delete(); dq.delete(); ed.delete(); iq.delete();
  endtask

  function automatic void exp_grant(logic [31:0] d);
    logic [31:0] e;
    wr_t w;
    e = (d == 0) ? 32'd1 : d;
    w.cyc = 0;
    w.a = 3'd2; w.d = e[15:0];  ew.push_back(w);
    w.a = 3'd3; w.d = e[31:16]; ew.push_back(w);
    w.a = 3'd1; w.d = 16'h0005; ew.push_back(w);
    w.a = 3'd0; w.d = 16'h0000; ew.push_back(w);
  endfunction

  // Requests held until their hold count of done pulses; grants go round-robin.
  function automatic void model_run(input logic [3:0] mask, input int holds[4], input logic [127:0] dl);
    logic [3:0] m;
    int h[4];
    m = mask;
    h = holds;
    while (m != 0) begin
      for (int j = 0; j < 4; j++) begin
        int k;
        k = (mptr + j) % 4;
        if (m[k]) begin
          exp_grant(dl[k*32 +: 32]);
          ed.push_back(k);
          mptr = (k + 1) % 4;
          h[k]--;
          if (h[k] <= 0) m[k] = 1'b0;
          break;
        end
      end
    end
  endfunction

  task automatic wait_done(input int n, input int budget, output bit ok);
    int start;
    start = dq.size();
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      for (int i = 0; i < 4; i++)
        if (done[i]) begin
          hold_n[i]--;
          if (hold_n[i] <= 0) req[i] = 1'b0;
        end
      if (dq.size() - start >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; req_delay = '0;
    repeat (3) tick();
    n_checks++;
    if ({done, busy, owner, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata} !==
        {4'b0, 1'b0, 2'b0, 1'b0, 1'b1, 3'b0, 16'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got done=%b busy=%b owner=%0d cs=%b wn=%b a=%0d d=%h",
               done, busy, owner, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
    reset = 1'b0;
    mptr = 0;
    tick();
  endtask

  task automatic test_single();
    int c0; bit ok;
    int holds[4] = '{1, 1, 1, 1};
    clear_logs();
    req_delay[1*32 +: 32] = 32'd100;
    hold_n = holds;
    model_run(4'b0010, holds, req_delay);
    req[1] = 1'b1; c0 = cyc;
    wait_done(1, 400, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got no done expected done"); end
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    n_checks++;
    if (wq.size() != ew.size()) begin n_fail++; $display("FAIL single_wr_count: got %0d expected %0d", wq.size(), ew.size()); end
    else foreach (ew[i]) begin
      n_checks++;
      if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) begin
        n_fail++; $display("FAIL single_wr%0d: got a=%0d d=%h expected a=%0d d=%h", i, wq[i].a, wq[i].d, ew[i].a, ew[i].d);
      end
    end
    if (wq.size() == 4 && dq.size() == 1 && iq.size() == 1) begin
      n_checks++; if (wq[0].cyc != c0 + 1) begin n_fail++; $display("FAIL single_first_write: got cyc %0d expected %0d", wq[0].cyc, c0 + 1); end
      n_checks++; if (dq[0].idx != 1) begin n_fail++; $display("FAIL single_done_idx: got %0d expected 1", dq[0].idx); end
      n_checks++; if (dq[0].cyc != wq[2].cyc + 103) begin n_fail++; $display("FAIL single_done_time: got %0d expected %0d", dq[0].cyc, wq[2].cyc + 103); end
      n_checks++; if (dq[0].cyc != iq[0] + 2 || wq[3].cyc != iq[0] + 1) begin
        n_fail++; $display("FAIL single_irq_to_done: got clr %0d done %0d expected %0d %0d", wq[3].cyc, dq[0].cyc, iq[0] + 1, iq[0] + 2);
      end
    end
  endtask

  task automatic test_long();
    bit ok;
    int holds[4] = '{1, 1, 1, 1};
    clear_logs();
    req_delay[0 +: 32] = 32'h0001_0003;
    hold_n = holds;
    model_run(4'b0001, holds, req_delay);
    req[0] = 1'b1;
    wait_done(1, 66000, ok);
    tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL long_timeout: got no done expected done"); end
    n_checks++;
    if (wq.size() != ew.size()) begin n_fail++; $display("FAIL long_wr_count: got %0d expected %0d", wq.size(), ew.size()); end
    else foreach (ew[i]) begin
      n_checks++;
      if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) begin
        n_fail++; $display("FAIL long_wr%0d: got a=%0d d=%h expected a=%0d d=%h", i, wq[i].a, wq[i].d, ew[i].a, ew[i].d);
      end
    end
    if (wq.size() == 4 && dq.size() == 1) begin
      n_checks++; if (dq[0].cyc - wq[2].cyc != 65539 + 3 || dq[0].idx != 0) begin
        n_fail++; $display("FAIL long_done: got idx %0d after %0d cycles expected idx 0 after %0d", dq[0].idx, dq[0].cyc - wq[2].cyc, 65542);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int holds[4] = '{2, 1, 1, 1};
    reset = 1'b1; tick(); tick(); reset = 1'b0; mptr = 0;
    clear_logs();
    req_delay[0 +: 32] = 32'd10; req_delay[64 +: 32] = 32'd10; req_delay[96 +: 32] = 32'd10;
    hold_n = holds;
    model_run(4'b1101, holds, req_delay);
    req = 4'b1101;
    wait_done(4, 600, ok);
    tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_timeout: got %0d dones expected 4", dq.size()); end
    n_checks++;
    if (dq.size() != ed.size()) begin n_fail++; $display("FAIL rr_done_count: got %0d expected %0d", dq.size(), ed.size()); end
    else foreach (ed[i]) begin
      n_checks++;
      if (dq[i].idx != ed[i]) begin n_fail++; $display("FAIL rr_order%0d: got %0d expected %0d", i, dq[i].idx, ed[i]); end
    end
    n_checks++;
    if (wq.size() != ew.size()) begin n_fail++; $display("FAIL rr_wr_count: got %0d expected %0d", wq.size(), ew.size()); end
    else begin
      foreach (ew[i]) begin
        n_checks++;
        if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) begin
          n_fail++; $display("FAIL rr_wr%0d: got a=%0d d=%h expected a=%0d d=%h", i, wq[i].a, wq[i].d, ew[i].a, ew[i].d);
        end
      end
      for (int g = 1; g < 4 && g < dq.size(); g++) begin
        n_checks++;
        if (wq[4*g].cyc != dq[g-1].cyc + 2) begin
          n_fail++; $display("FAIL rr_idle_gap%0d: got %0d expected %0d", g, wq[4*g].cyc, dq[g-1].cyc + 2);
        end
      end
    end
  endtask

  task automatic test_cancel();
    bit ok; int cdrop;
    wr_t w;
    clear_logs();
    req_delay[64 +: 32] = 32'd1000; req_delay[96 +: 32] = 32'd5;
    hold_n[2] = 1; hold_n[3] = 1;
    exp_grant(32'd1000);
    void'(ew.pop_back());
    w.cyc = 0; w.a = 3'd1; w.d = 16'h0008; ew.push_back(w);
    w.a = 3'd0; w.d = 16'h0000; ew.push_back(w);
    exp_grant(32'd5);
    ed.push_back(3);
    mptr = 0;
    req[2] = 1'b1; req[3] = 1'b1;
    for (int c = 0; c < 50 && wq.size() < 3; c++) tick();
    repeat (50) tick();
    req[2] = 1'b0; cdrop = cyc;
    wait_done(1, 300, ok);
    tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL cancel_timeout: got no done expected done[3]"); end
    n_checks++;
    if (dq.size() != 1 || dq[0].idx != 3) begin
      n_fail++; $display("FAIL cancel_done: got %0d pulses first %0d expected 1 pulse idx 3", dq.size(), (dq.size() > 0) ? dq[0].idx : -1);
    end
    n_checks++;
    if (wq.size() != ew.size()) begin n_fail++; $display("FAIL cancel_wr_count: got %0d expected %0d", wq.size(), ew.size()); end
    else begin
      foreach (ew[i]) begin
        n_checks++;
        if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) begin
          n_fail++; $display("FAIL cancel_wr%0d: got a=%0d d=%h expected a=%0d d=%h", i, wq[i].a, wq[i].d, ew[i].a, ew[i].d);
        end
      end
      n_checks++;
      if (wq[3].cyc != cdrop + 1 || wq[5].cyc != cdrop + 5) begin
        n_fail++; $display("FAIL cancel_timing: got stop %0d next %0d expected %0d %0d", wq[3].cyc, wq[5].cyc, cdrop + 1, cdrop + 5);
      end
    end
  endtask

  task automatic test_zero_sim();
    bit ok;
    int holds[4] = '{1, 1, 1, 1};
    clear_logs();
    req_delay[32 +: 32] = 32'd0;
    hold_n = holds;
    model_run(4'b0010, holds, req_delay);
    req[1] = 1'b1;
    wait_done(1, 100, ok);
    tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_timeout: got no done expected done[1]"); end
    n_checks++;
    if (wq.size() != 4 || dq.size() != 1) begin n_fail++; $display("FAIL zero_counts: got %0d writes %0d dones expected 4 1", wq.size(), dq.size()); end
    else begin
      n_checks++;
      if (wq[0].d !== ew[0].d || wq[1].d !== ew[1].d || dq[0].cyc - wq[2].cyc != 4) begin
        n_fail++; $display("FAIL zero_prog: got pl=%h ph=%h lat=%0d expected pl=%h ph=%h lat=4", wq[0].d, wq[1].d, dq[0].cyc - wq[2].cyc, ew[0].d, ew[1].d);
      end
    end
    // irq and cancel in the same cycle: irq must win
    clear_logs();
    req_delay[32 +: 32] = 32'd20;
    hold_n = holds;
    model_run(4'b0010, holds, req_delay);
    req[1] = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (tmr_irq) break;
    end
    req[1] = 1'b0;
    wait_done(1, 20, ok);
    tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sim_timeout: got no done expected done[1]"); end
    n_checks++;
    if (wq.size() != ew.size()) begin n_fail++; $display("FAIL sim_wr_count: got %0d expected %0d", wq.size(), ew.size()); end
    else foreach (ew[i]) begin
      n_checks++;
      if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) begin
        n_fail++; $display("FAIL sim_wr%0d: got a=%0d d=%h expected a=%0d d=%h", i, wq[i].a, wq[i].d, ew[i].a, ew[i].d);
      end
    end
  endtask

  task automatic test_reset_wait();
    bit ok; int rc;
    int holds[4] = '{1, 1, 1, 1};
    clear_logs();
    req_delay[0 +: 32] = 32'd1000;
    hold_n = holds;
    req[0] = 1'b1;
    for (int c = 0; c < 50 && wq.size() < 3; c++) tick();
    repeat (10) tick();
    n_checks++; if (busy !== 1'b1 || owner !== 2'd0) begin n_fail++; $display("FAIL rstw_busy_before: got busy=%b owner=%0d expected 1 0", busy, owner); end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({busy, tmr_chipselect, tmr_write_n, done} !== {1'b0, 1'b0, 1'b1, 4'b0}) begin
      n_fail++; $display("FAIL rstw_idle: got busy=%b cs=%b wn=%b done=%b expected 0 0 1 0000", busy, tmr_chipselect, tmr_write_n, done);
    end
    reset = 1'b0; rc = cyc;
    clear_logs();
    mptr = 0;
    model_run(4'b0001, holds, req_delay);
    wait_done(1, 1300, ok);
    tick();
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rstw_timeout: got no done expected done[0]"); end
    n_checks++;
    if (wq.size() != ew.size()) begin n_fail++; $display("FAIL rstw_wr_count: got %0d expected %0d", wq.size(), ew.size()); end
    else begin
      foreach (ew[i]) begin
        n_checks++;
        if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) begin
          n_fail++; $display("FAIL rstw_wr%0d: got a=%0d d=%h expected a=%0d d=%h", i, wq[i].a, wq[i].d, ew[i].a, ew[i].d);
        end
      end
      n_checks++; if (wq[0].cyc != rc + 1) begin n_fail++; $display("FAIL rstw_restart: got %0d expected %0d", wq[0].cyc, rc + 1); end
    end
  endtask

  task automatic test_random();
    bit ok; int total;
    logic [3:0] mask;
    int holds[4];
    for (int r = 0; r < 6; r++) begin
      clear_logs();
      mask = 4'($urandom_range(1, 15));
      total = 0;
      for (int i = 0; i < 4; i++) begin
        req_delay[i*32 +: 32] = 32'($urandom_range(0, 30));
        holds[i] = $urandom_range(1, 2);
        if (mask[i]) total += holds[i];
      end
      hold_n = holds;
      model_run(mask, holds, req_delay);
      req = mask;
      wait_done(total, 2000, ok);
      tick();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL rand%0d_timeout: got %0d dones expected %0d", r, dq.size(), total); end
      n_checks++;
      if (dq.size() != ed.size()) begin n_fail++; $display("FAIL rand%0d_done_count: got %0d expected %0d", r, dq.size(), ed.size()); end
      else foreach (ed[i]) begin
        n_checks++;
        if (dq[i].idx != ed[i]) begin n_fail++; $display("FAIL rand%0d_order%0d: got %0d expected %0d", r, i, dq[i].idx, ed[i]); end
      end
      n_checks++;
      if (wq.size() != ew.size()) begin n_fail++; $display("FAIL rand%0d_wr_count: got %0d expected %0d", r, wq.size(), ew.size()); end
      else foreach (ew[i]) begin
        n_checks++;
        if (wq[i].a !== ew[i].a || wq[i].d !== ew[i].d) begin
          n_fail++; $display("FAIL rand%0d_wr%0d: got a=%0d d=%h expected a=%0d d=%h", r, i, wq[i].a, wq[i].d, ew[i].a, ew[i].d);
        end
      end
    end
  endtask

  initial begin
    req = '0; req_delay = '0; reset = 1'b1;
    hold_n = '{1, 1, 1, 1};
    test_reset();
    test_single();
    test_long();
    test_round_robin();
    test_cancel();
    test_zero_sim();
    test_reset_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
